// File: rtl/down_counter_sched_pkg.sv
// Shared definitions for the round-robin down-counter scheduler.
//   state_t   : FSM state encoding (IDLE, LOAD, COUNT, DONE)
//   NREQ_DEF  : default number of requesters
//   N_DEF     : default counter width
//   MAX_NREQ  : largest supported requester count
//   IDX_W     : index width able to address MAX_NREQ requesters
//   onehot()  : index to one-hot vector of MAX_NREQ bits
package down_counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int N_DEF    = 8;
    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = 3;

    // Callers size-cast the result down to their own requester count.
    function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req   in  NREQ  request vector
//   ptr   in  SW    highest-priority index for this pick
//   valid out 1     at least one request is set
//   idx   out SW    first set request at or after ptr, wrapping past NREQ-1
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic            valid,
    output logic [SW-1:0]   idx
);

    int          cand;
    logic [SW-1:0] cand_idx;

    // Scan offsets from the farthest to the nearest so the candidate closest
    // to ptr is the one left standing.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = SW'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/down_counter_sched.sv
// Round-robin scheduler sharing one N-bit down counter among NREQ requesters.
//   clk       in  1       clock, rising edge
//   rst       in  1       synchronous active-high reset
//   req       in  NREQ    level requests, looked at only while idle
//   req_len   in  NREQ*N  packed delays, requester k at [k*N +: N]
//   abort     in  1       cancels the service in progress (LOAD/COUNT only)
//   grant     out NREQ    one-hot owner of the counter, zero when idle
//   busy      out 1       scheduler is not idle
//   count_out out N       shared counter value
//   done      out NREQ    one-cycle pulse for the requester just served
module down_counter_sched
    import down_counter_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int N    = N_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*N-1:0] req_len,
    input  logic            abort,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic [N-1:0]    count_out,
    output logic [NREQ-1:0] done
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, nxt_state;
    logic [SW-1:0]   sel, nxt_sel;
    logic [SW-1:0]   ptr, nxt_ptr;
    logic [NREQ-1:0] nxt_grant, nxt_done;
    logic            nxt_busy;
    logic [N-1:0]    nxt_count;
    logic [N-1:0]    len_sel;

    logic            arb_valid;
    logic [SW-1:0]   arb_idx;

    // Priority rotates to the requester after the one just served.
    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
        if (i == SW'(NREQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign len_sel = req_len[int'(sel)*N +: N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            ptr       <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            count_out <= '0;
        end else begin
            state     <= nxt_state;
            sel       <= nxt_sel;
            ptr       <= nxt_ptr;
            grant     <= nxt_grant;
            done      <= nxt_done;
            busy      <= nxt_busy;
            count_out <= nxt_count;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_sel   = sel;
        nxt_ptr   = ptr;
        nxt_grant = grant;
        nxt_done  = '0;
        nxt_busy  = busy;
        nxt_count = count_out;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    nxt_state = LOAD;
                    nxt_sel   = arb_idx;
                    nxt_grant = NREQ'(onehot(IDX_W'(arb_idx)));
                    nxt_busy  = 1'b1;
                end
            end

            LOAD: begin
                if (abort) begin
                    nxt_state = IDLE;
                    nxt_grant = '0;
                    nxt_count = '0;
                    nxt_busy  = 1'b0;
                    nxt_ptr   = next_idx(sel);
                end else begin
                    nxt_count = len_sel;
                    nxt_state = COUNT;
                end
            end

            COUNT: begin
                // abort takes precedence over reaching zero: no done pulse.
                if (abort) begin
                    nxt_state = IDLE;
                    nxt_grant = '0;
                    nxt_count = '0;
                    nxt_busy  = 1'b0;
                    nxt_ptr   = next_idx(sel);
                end else if (count_out == '0) begin
                    nxt_state = DONE;
                    nxt_done  = NREQ'(onehot(IDX_W'(sel)));
                end else begin
                    nxt_count = count_out - 1'b1;
                end
            end

            DONE: begin
                nxt_state = IDLE;
                nxt_grant = '0;
                nxt_busy  = 1'b0;
                nxt_ptr   = next_idx(sel);
            end

            default: begin
                nxt_state = IDLE;
                nxt_grant = '0;
                nxt_busy  = 1'b0;
                nxt_count = '0;
            end
        endcase
    end

endmodule

// File: doc/down_counter_sched.md
Name: down_counter_sched

Overview:
- Round-robin scheduler that shares one N-bit down counter among NREQ requesters.
- Each requester asks for a delay of req_len cycles. The block grants one requester at a time, loads the shared counter, counts down to zero and returns a one-cycle done pulse to the granted requester.
- Sits between per-channel control logic and the shared countdown datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N, 8, counter width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; sampled only in IDLE.
- req_len  in  NREQ*N  packed delay values; requester k uses bits [k*N +: N]; sampled in LOAD.
- abort  in  1  cancels the current service; honoured only in LOAD or COUNT.
- grant  out  NREQ  one-hot owner of the counter; all zero when idle.
- busy  out  1  high whenever state is not IDLE.
- count_out  out  N  shared counter value.
- done  out  NREQ  one-cycle pulse on the bit of the requester just served.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) sets:
  - state=IDLE, grant=0, done=0, busy=0, count_out=0;
  - priority pointer=0, so req[0] has highest priority.
  - Reset overrides every other input, including mid-COUNT.
- All outputs are registered.
- FSM states are IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from the pointer upward with wrap-around.
  - Next state is LOAD; grant becomes one-hot(sel), sel is latched, busy becomes 1.
  - If req is zero, stay in IDLE.
- LOAD:
  - count_out <= req_len[sel]; next state is COUNT.
  - If abort=1, go to IDLE instead: grant=0, count_out=0, busy=0, no done, pointer <= sel+1 mod NREQ.
- COUNT:
  - If abort=1, take the same abort action as in LOAD.
  - Otherwise, if count_out==0, go to DONE, set done[sel]=1 and hold count_out at 0.
  - Otherwise count_out <= count_out-1. It never wraps below 0.
- DONE (exactly one cycle):
  - done[sel] is high and grant is still held.
  - At the next edge: done=0, grant=0, busy=0, pointer <= sel+1 mod NREQ, state=IDLE.
- Timing, for a request sampled at edge E with length L:
  - grant visible after E;
  - count_out=L after E+1, reaching 0 after E+1+L;
  - done high for the cycle after E+L+2;
  - grant and busy clear after E+L+3.
- Minimum turnaround between grants is one IDLE cycle.
- req_len=0 is legal: count_out loads 0 and done is set after E+2.
- A requester dropping req during service is ignored and the service completes.
- A requester holding req after done is re-eligible, but only after every other pending requester, because the pointer has advanced.
- Changes on req_len after LOAD do not affect the current service.
- abort in IDLE or DONE has no effect.
- Simultaneous abort and count_out==0 in COUNT: abort wins, so no done.
- done and grant are never nonzero for two different requesters.
- At most one done bit is high in any cycle.

Decomposition:
- Package down_counter_sched_pkg holds:
  - state enum {IDLE, LOAD, COUNT, DONE} (2-bit encoding);
  - localparam defaults for NREQ and N;
  - function onehot(idx).
- Sub-module rr_arbiter, parameterised by NREQ: combinational pick of the first set bit of req at or after the pointer, with wrap-around. Outputs a valid flag and the index. The pointer register lives in the parent.

Test Plan:
- Single request, normal length: NREQ=4, N=8, reset, then req=0001 with len0=3 sampled at edge 1.
  - grant=0001 after edge 1; count_out 3,2,1,0 after edges 2..5.
  - done=0001 for one cycle after edge 6; grant=0, busy=0 after edge 7.
- Zero length: req=0100 with len2=0.
  - grant=0100; count_out=0 after edge 2; done=0100 after edge 3; idle after edge 4.
- Fairness: req=1111 held, all lengths 1.
  - Grants served in order 0001, 0010, 0100, 1000, 0001.
  - Each done lands on the matching bit; one idle cycle between services.
- Pointer wrap: service req[3] first, then assert req=1001.
  - Next grant is 0001 (pointer wraps to 0), then 1000.
- Abort: req[1] with len 10; assert abort when count_out=6.
  - Next cycle grant=0, count_out=0, busy=0, done never set.
  - Subsequent req=0011 grants 0100? No: it grants 0001, because the pointer moved to 2, wraps, and the first set bit found is 0.
- Reset mid-operation: assert rst while count_out=5.
  - After that edge: state IDLE, grant=0, done=0, busy=0, count_out=0.
  - req=0010 then grants 0010.
